// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: load-use stall, branch flush, memory-wait hold with timeout; outputs combinational, state registered.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] IF_ID_RS1addr_i,
  input  logic [4:0] IF_ID_RS2addr_i,
  input  logic       ID_EX_MemRead_i,
  input  logic [4:0] ID_EX_RDaddr_i,
  input  logic       branch_taken_i,
  input  logic       mem_req_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       IF_ID_write_o,
  output logic       IF_ID_flush_o,
  output logic       ID_EX_bubble_o,
  output logic       pipe_hold_o,
  output logic       mem_err_o,
  output logic [1:0] state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERROR    = 2'b10
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_err_q;
  logic       load_use;
  logic       mem_wait;

  assign load_use = ID_EX_MemRead_i && (ID_EX_RDaddr_i != 5'd0) &&
                    ((ID_EX_RDaddr_i == IF_ID_RS1addr_i) || (ID_EX_RDaddr_i == IF_ID_RS2addr_i));
  assign mem_wait = mem_req_i && !mem_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 8'd0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (state_d == ST_ERROR) mem_err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    PCWrite_o      = 1'b1;
    IF_ID_write_o  = 1'b1;
    IF_ID_flush_o  = 1'b0;
    ID_EX_bubble_o = 1'b0;
    pipe_hold_o    = 1'b0;
    case (state_q)
      ST_RUN: begin
        wait_cnt_d = 8'd0;
        if (mem_wait) begin
          PCWrite_o     = 1'b0;
          IF_ID_write_o = 1'b0;
          pipe_hold_o   = 1'b1;
          state_d       = ST_MEM_WAIT;
        end else if (load_use) begin
          // Stall beats flush: the branch is re-resolved once the load lands.
          PCWrite_o      = 1'b0;
          IF_ID_write_o  = 1'b0;
          ID_EX_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
          IF_ID_flush_o = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready_i) begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end else begin
          PCWrite_o     = 1'b0;
          IF_ID_write_o = 1'b0;
          pipe_hold_o   = 1'b1;
          if (wait_cnt_q == WAIT_LAST) state_d = ST_ERROR;
          else wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_ERROR: begin
        PCWrite_o     = 1'b0;
        IF_ID_write_o = 1'b0;
        pipe_hold_o   = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
    if (rst_i) begin
      PCWrite_o      = 1'b0;
      IF_ID_write_o  = 1'b0;
      IF_ID_flush_o  = 1'b1;
      ID_EX_bubble_o = 1'b1;
      pipe_hold_o    = 1'b0;
    end
  end

  assign mem_err_o = mem_err_q;
  assign state_o   = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (!PCWrite_o && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (IF_ID_flush_o && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4); counter checks only with HAZARD_PERF_CNT_EN.
module tb_pipeline_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] rs1, rs2, rd;
  logic       mem_read, branch, mem_req, mem_ready;
  logic       pc_write, ifid_write, ifid_flush, bubble, hold, mem_err;
  logic [1:0] state;
  logic [7:0] outs;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .IF_ID_RS1addr_i(rs1),
    .IF_ID_RS2addr_i(rs2),
    .ID_EX_MemRead_i(mem_read),
    .ID_EX_RDaddr_i (rd),
    .branch_taken_i (branch),
    .mem_req_i      (mem_req),
    .mem_ready_i    (mem_ready),
    .PCWrite_o      (pc_write),
    .IF_ID_write_o  (ifid_write),
    .IF_ID_flush_o  (ifid_flush),
    .ID_EX_bubble_o (bubble),
    .pipe_hold_o    (hold),
    .mem_err_o      (mem_err),
    .state_o        (state)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
`endif
  );

  // {PCWrite, IF_ID_write, flush, bubble, hold, mem_err, state[1:0]}
  assign outs = {pc_write, ifid_write, ifid_flush, bubble, hold, mem_err, state};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Inputs are already applied; compare this cycle's outputs, then advance one edge.
  task automatic step(input string tag, input logic [7:0] exp);
    #1;
    chk(tag, {8'd0, outs}, {8'd0, exp});
    tick();
  endtask

  task automatic clr_in();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    mem_read = 1'b0; branch = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    clr_in();
    rst_i = 1'b1;
    tick();
    step("reset_outputs", 8'b0011_0000);
    rst_i = 1'b0;
    step("idle_run", 8'b1100_0000);

    // load-use through rs2, then bubble gone
    mem_read = 1'b1; rd = 5'd5; rs2 = 5'd5; rs1 = 5'd1;
    step("load_use_rs2", 8'b0001_0000);
    mem_read = 1'b0;
    step("after_stall", 8'b1100_0000);
    mem_read = 1'b1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    step("rd_zero_no_stall", 8'b1100_0000);

    // stall beats branch, branch flushes next cycle
    mem_read = 1'b1; rd = 5'd7; rs1 = 5'd7; rs2 = 5'd3; branch = 1'b1;
    step("stall_over_branch", 8'b0001_0000);
    mem_read = 1'b0;
    step("branch_flush", 8'b1110_0000);
    clr_in();

    // memory wait 3 cycles then ready
    mem_req = 1'b1;
    step("mw_enter", 8'b0000_1000);
    mem_read = 1'b1; rd = 5'd5; rs2 = 5'd5; branch = 1'b1;
    step("mw_ignore_haz", 8'b0000_1001);
    mem_read = 1'b0; branch = 1'b0;
    step("mw_hold3", 8'b0000_1001);
    mem_ready = 1'b1;
    step("mw_release", 8'b1100_0001);
    clr_in();
    step("mw_back_run", 8'b1100_0000);

    // ready on the last allowed wait cycle wins over timeout
    mem_req = 1'b1;
    step("tr_enter", 8'b0000_1000);
    step("tr_w0", 8'b0000_1001);
    step("tr_w1", 8'b0000_1001);
    step("tr_w2", 8'b0000_1001);
    mem_ready = 1'b1;
    step("tr_w3_ready", 8'b1100_0001);
    clr_in();
    step("tr_no_error", 8'b1100_0000);

    // timeout to ERROR
    mem_req = 1'b1;
    step("to_enter", 8'b0000_1000);
    step("to_w0", 8'b0000_1001);
    step("to_w1", 8'b0000_1001);
    step("to_w2", 8'b0000_1001);
    step("to_w3", 8'b0000_1001);
    step("to_error", 8'b0000_1110);
    mem_ready = 1'b1;
    step("error_sticky", 8'b0000_1110);
    clr_in();
    step("error_sticky2", 8'b0000_1110);

    // reset out of ERROR
    rst_i = 1'b1;
    step("rst_in_error", 8'b0011_0110);
    step("rst_cleared", 8'b0011_0000);
    rst_i = 1'b0;
    step("run_after_rst", 8'b1100_0000);

    // reset mid-wait
    mem_req = 1'b1;
    step("rmw_enter", 8'b0000_1000);
    step("rmw_wait", 8'b0000_1001);
    rst_i = 1'b1;
    step("rmw_rst", 8'b0011_0001);
    rst_i = 1'b0;
    clr_in();
    step("rmw_run", 8'b1100_0000);

`ifdef HAZARD_PERF_CNT_EN
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    chk("cnt_reset_stall", stall_cnt, 16'd0);
    chk("cnt_reset_flush", flush_cnt, 16'd0);
    mem_read = 1'b1; rd = 5'd9; rs1 = 5'd9;
    tick();
    mem_read = 1'b0;
    tick();
    mem_read = 1'b1; rs1 = 5'd2; rs2 = 5'd9;
    tick();
    clr_in();
    branch = 1'b1;
    tick();
    branch = 1'b0;
    tick();
    chk("stall_cnt_2", stall_cnt, 16'd2);
    chk("flush_cnt_1", flush_cnt, 16'd1);
    force dut.stall_cnt_q = 16'hFFFF;
    force dut.flush_cnt_q = 16'hFFFF;
    #1;
    release dut.stall_cnt_q;
    release dut.flush_cnt_q;
    mem_read = 1'b1; rd = 5'd4; rs1 = 5'd4; branch = 1'b0;
    tick();
    clr_in();
    branch = 1'b1;
    tick();
    clr_in();
    #1;
    chk("stall_cnt_sat", stall_cnt, 16'hFFFF);
    chk("flush_cnt_sat", flush_cnt, 16'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
